// File: rtl/keypad_emulator.sv
// keypad_emulator: passive 4x4 matrix keypad model. Queued keycodes are
// "pressed" for HOLD_CYCLES clocks and released for GAP_CYCLES clocks; while
// a key is held, the active-low column scan is answered on the row lines.
module keypad_emulator #(
  parameter int HOLD_CYCLES = 600000,
  parameter int GAP_CYCLES  = 600000,
  parameter int DEPTH       = 8
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       busy,
  output logic       pressed,
  output logic [3:0] cur_code,
  output logic       key_done,
  output logic [7:0] press_count
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int NW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] HOLD_L = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_L  = CW'(GAP_CYCLES - 1);
  localparam logic [NW-1:0] FULL   = NW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pop, done;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count, count_next;
  logic          push;

  logic [1:0]    key_row, key_col;

  assign push = key_valid && key_ready;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // FIFO storage; contents need no reset, the pointers/count guard them
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  // FIFO pointers, count and registered ready (low only when full)
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      key_ready <= (count_next != FULL);
    end
  end

  // press/gap sequencing; one shared down-counter times both phases
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          cnt_next   = HOLD_L;
          state_next = S_PRESS;
        end
      end
      S_PRESS: begin
        if (cnt == '0) begin
          cnt_next   = GAP_L;
          state_next = S_GAP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // state, counter, held keycode and completion count
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cur_code    <= '0;
      press_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (pop)  cur_code    <= mem[rd_ptr];
      if (done) press_count <= press_count + 1'b1;
    end
  end

  assign pressed  = (state == S_PRESS);
  assign key_done = done;
  assign busy     = (state != S_IDLE) || (count != '0);

  // fixed keymap: cur_code -> (row, col)
  always_comb begin
    key_row = 2'd0;
    key_col = 2'd0;
    case (cur_code)
      4'h1: begin key_row = 2'd0; key_col = 2'd0; end
      4'h2: begin key_row = 2'd0; key_col = 2'd1; end
      4'h3: begin key_row = 2'd0; key_col = 2'd2; end
      4'hA: begin key_row = 2'd0; key_col = 2'd3; end
      4'h4: begin key_row = 2'd1; key_col = 2'd0; end
      4'h5: begin key_row = 2'd1; key_col = 2'd1; end
      4'h6: begin key_row = 2'd1; key_col = 2'd2; end
      4'hB: begin key_row = 2'd1; key_col = 2'd3; end
      4'h7: begin key_row = 2'd2; key_col = 2'd0; end
      4'h8: begin key_row = 2'd2; key_col = 2'd1; end
      4'h9: begin key_row = 2'd2; key_col = 2'd2; end
      4'hC: begin key_row = 2'd2; key_col = 2'd3; end
      4'h0: begin key_row = 2'd3; key_col = 2'd0; end
      4'hF: begin key_row = 2'd3; key_col = 2'd1; end
      4'hE: begin key_row = 2'd3; key_col = 2'd2; end
      4'hD: begin key_row = 2'd3; key_col = 2'd3; end
      default: begin key_row = 2'd0; key_col = 2'd0; end
    endcase
  end

  // passive switch: zero-latency path from column drive to row sense
  always_comb begin
    row_out = 4'hF;
    if (pressed && !col_in[key_col]) row_out[key_row] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: accepted keycodes are queued, and a
// negedge monitor checks press order, hold/gap lengths, row response and
// counters against a keymap-table reference model.
module tb_keypad_emulator;
  localparam int HOLD  = 8;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       reset;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       busy, pressed, key_done;
  logic [3:0] cur_code;
  logic [7:0] press_count;

  keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .col_in(col_in), .row_out(row_out), .busy(busy),
    .pressed(pressed), .cur_code(cur_code), .key_done(key_done),
    .press_count(press_count)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] sb[$];
  logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: locate the key on the printed keypad layout
  function automatic logic [3:0] exp_row(input logic [3:0] code, input logic [3:0] col, input bit on);
    int idx = 0;
    logic [3:0] r = 4'hF;
    for (int i = 0; i < 16; i++) if (layout[i] == code) idx = i;
    if (on && !col[idx % 4]) r[idx / 4] = 1'b0;
    return r;
  endfunction

  // column driver: fixed pattern or random scan
  bit         rand_col = 0;
  logic [3:0] col_fixed = 4'hF;
  always @(negedge Clk) begin
    #1 col_in = rand_col ? 4'($urandom) : col_fixed;
  end

  // monitor / scoreboard
  bit         prev_pressed = 0, in_gap = 0, chk_gap = 0, cnt_pending = 0;
  int         hold_len = 0, gap_len = 0;
  logic [3:0] held = 4'h0;
  logic [7:0] model_cnt = 8'd0;

  always @(negedge Clk) begin
    bit gap_act;
    gap_act = 0;
    if (reset) begin
      sb.delete();
      prev_pressed = 0; in_gap = 0; chk_gap = 0; cnt_pending = 0;
      hold_len = 0; gap_len = 0; model_cnt = 8'd0; held = 4'h0;
    end else begin
      if (cnt_pending) begin
        chk("press_count", press_count, model_cnt);
        cnt_pending = 0;
      end
      if (pressed) begin
        if (!prev_pressed) begin
          if (sb.size() == 0) chk("unexpected_press", 1, 0);
          else begin
            held = sb.pop_front();
            chk("cur_code", cur_code, held);
          end
          if (chk_gap) chk("released_len", gap_len, GAP + 1);
          chk_gap = 0;
          hold_len = 0;
        end
        hold_len++;
        chk("key_done_in_press", key_done, 0);
      end else begin
        if (prev_pressed) begin
          chk("hold_len", hold_len, HOLD);
          in_gap = 1;
          gap_len = 0;
        end
        gap_len++;
        if (in_gap) begin
          gap_act = 1;
          chk("key_done", key_done, gap_len == GAP);
          if (gap_len == GAP) begin
            in_gap = 0;
            model_cnt = model_cnt + 8'd1;
            cnt_pending = 1;
            chk_gap = (sb.size() != 0);
          end
        end else begin
          chk("key_done_idle", key_done, 0);
        end
      end
      chk("busy", busy, pressed || gap_act || sb.size() != 0);
      chk("row_out", row_out, exp_row(held, col_in, pressed));
      prev_pressed = pressed;
    end
  end

  task automatic push_key(input logic [3:0] c, output bit acc);
    @(negedge Clk); #1;
    key_code = c; key_valid = 1'b1;
    acc = key_ready;
    if (acc) sb.push_back(c);
    @(posedge Clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge Clk); n++; end while (busy && n < 3000);
    chk("wait_idle", busy, 0);
  endtask

  task automatic wait_press();
    int n = 0;
    do begin @(negedge Clk); n++; end while (!pressed && n < 3000);
    chk("wait_press", pressed, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int acc_n;
    int dn, pn;
    logic [3:0] corner [4]  = '{4'h1, 4'hD, 4'h0, 4'hA};
    logic [3:0] mcol   [4]  = '{4'b1110, 4'b0111, 4'b1110, 4'b0111};
    logic [3:0] ncol   [4]  = '{4'b1101, 4'b1011, 4'b1101, 4'b1011};
    logic [3:0] mrow   [4]  = '{4'b1110, 4'b0111, 4'b0111, 4'b1110};
    logic [3:0] toggles[4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_row_out", row_out, 4'hF);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pressed", pressed, 0);
    chk("rst_press_count", press_count, 0);
    chk("rst_cur_code", cur_code, 0);
    chk("rst_key_done", key_done, 0);
    #1 reset = 1'b0;

    // idle: column scan sees no key
    for (int i = 0; i < 4; i++) begin
      col_fixed = toggles[i];
      @(negedge Clk); @(negedge Clk);
      chk("idle_row_out", row_out, 4'hF);
    end
    col_fixed = 4'hF;

    // single key 5
    push_key(4'h5, acc);
    chk("single_acc", acc, 1);
    wait_press();
    col_fixed = 4'b1101;
    @(negedge Clk);
    chk("single_match", row_out, 4'b1101);
    col_fixed = 4'b1110;
    @(negedge Clk);
    chk("single_nomatch", row_out, 4'hF);
    col_fixed = 4'hF;
    wait_idle();
    chk("single_press_count", press_count, 1);

    // corner keys
    for (int i = 0; i < 4; i++) begin
      push_key(corner[i], acc);
      wait_press();
      col_fixed = mcol[i];
      @(negedge Clk);
      chk("corner_match", row_out, mrow[i]);
      col_fixed = ncol[i];
      @(negedge Clk);
      chk("corner_nomatch", row_out, 4'hF);
      col_fixed = 4'hF;
      wait_idle();
    end
    chk("corner_press_count", press_count, 5);

    // FIFO full: 6 back-to-back pushes while idle, 5 accepted
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      push_key(4'(i + 7), acc);
      if (acc) acc_n++;
      if (i == 5) chk("full_sixth_rejected", acc, 0);
    end
    chk("full_accepted", acc_n, 5);
    wait_idle();
    chk("full_press_count", press_count, 10);

    // randomized traffic with random column scanning
    rand_col = 1;
    for (int i = 0; i < 30; i++) begin
      push_key(4'($urandom), acc);
      repeat ($urandom_range(0, 14)) @(negedge Clk);
    end
    wait_idle();
    rand_col = 0;

    // reset mid-press: row releases asynchronously, queue dropped
    push_key(4'h5, acc);
    push_key(4'h7, acc);
    wait_press();
    col_fixed = 4'b1101;
    @(negedge Clk);
    @(negedge Clk);
    chk("midpress_row_before", row_out, 4'b1101);
    #2 reset = 1'b1;
    #1;
    chk("midpress_row_async", row_out, 4'hF);
    chk("midpress_pressed", pressed, 0);
    chk("midpress_key_ready", key_ready, 1);
    chk("midpress_busy", busy, 0);
    @(negedge Clk); @(negedge Clk);
    #1 reset = 1'b0;
    dn = 0; pn = 0;
    repeat (HOLD + GAP + 6) begin
      @(negedge Clk);
      if (key_done) dn++;
      if (pressed) pn++;
    end
    chk("midpress_no_done", dn, 0);
    chk("midpress_no_replay", pn, 0);
    chk("midpress_press_count", press_count, 0);
    col_fixed = 4'hF;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
